// File: rtl/frv_bram_arbiter.sv
// frv_bram_arbiter: shares one single-port BRAM between NPORTS requesters,
// fixed-priority or round-robin, with a starvation guard and per-port read responses.
module frv_bram_arbiter #(
    parameter int NPORTS   = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RR_MODE  = 0,
    parameter int MAX_WAIT = 15
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    input  logic [NPORTS-1:0]      req_cen,
    input  logic [NPORTS*AW-1:0]   req_addr,
    input  logic [NPORTS*DW-1:0]   req_wdata,
    input  logic [NPORTS*DW/8-1:0] req_wstrb,
    output logic [NPORTS-1:0]      req_stall,
    output logic [NPORTS-1:0]      rsp_rvalid,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   bram_cen,
    output logic [AW-1:0]          bram_addr,
    output logic [DW-1:0]          bram_wdata,
    output logic [DW/8-1:0]        bram_wstrb,
    input  logic [DW-1:0]          bram_rdata
);
    localparam int IW = NPORTS > 1 ? $clog2(NPORTS) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int SW = DW / 8;

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     rd_tag;
    logic              found;
    logic              rd_pend;
    logic [NPORTS-1:0] grant;
    logic [WW-1:0]     wait_cnt [NPORTS];
    int                cand;

    // Starved ports win first; otherwise scan from port 0 or from rr_ptr.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = 0;
        for (int i = 0; i < NPORTS; i++)
            if (!found && req_cen[i] && wait_cnt[i] == WW'(MAX_WAIT)) begin
                found = 1'b1;
                gidx  = IW'(i);
            end
        for (int k = 0; k < NPORTS; k++) begin
            cand = RR_MODE != 0 ? (int'(rr_ptr) + k) % NPORTS : k;
            if (!found && req_cen[IW'(cand)]) begin
                found = 1'b1;
                gidx  = IW'(cand);
            end
        end
    end

    assign grant      = {{(NPORTS-1){1'b0}}, found} << gidx;
    assign req_stall  = req_cen & ~grant;
    assign bram_cen   = |req_cen;
    assign bram_addr  = req_addr[gidx*AW +: AW];
    assign bram_wdata = req_wdata[gidx*DW +: DW];
    assign bram_wstrb = req_wstrb[gidx*SW +: SW];
    assign rsp_rdata  = bram_rdata;
    assign rsp_rvalid = g_reset ? '0 : {{(NPORTS-1){1'b0}}, rd_pend} << rd_tag;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rr_ptr  <= '0;
            rd_tag  <= '0;
            rd_pend <= 1'b0;
            for (int i = 0; i < NPORTS; i++) wait_cnt[i] <= '0;
        end else begin
            if (found) rr_ptr <= gidx == IW'(NPORTS-1) ? '0 : gidx + 1'b1;
            rd_tag  <= gidx;
            rd_pend <= found && bram_wstrb == '0;
            for (int i = 0; i < NPORTS; i++)
                wait_cnt[i] <= !req_stall[i] ? '0 :
                               wait_cnt[i] == WW'(MAX_WAIT) ? wait_cnt[i] : wait_cnt[i] + 1'b1;
        end
    end
endmodule

// File: tb/tb_frv_bram_arbiter.sv
// tb_frv_bram_arbiter: directed checks of a fixed-priority (MAX_WAIT=3) and a
// round-robin arbiter sharing one stimulus, plus a random invariant sweep.
module tb_frv_bram_arbiter;
    logic         g_clk = 1'b0;
    logic         g_reset;
    logic [3:0]   req_cen;
    logic [127:0] req_addr, req_wdata;
    logic [15:0]  req_wstrb;

    logic [3:0]  stall_f, rvalid_f, wstrb_f, stall_r, rvalid_r, wstrb_r;
    logic [31:0] rdata_f, addr_f, wdata_f, mem_rd_f, rdata_r, addr_r, wdata_r, mem_rd_r;
    logic        cen_f, cen_r;
    logic [31:0] mem_f [256];
    logic [31:0] mem_r [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 g_clk = ~g_clk;

    frv_bram_arbiter #(.NPORTS(4), .AW(32), .DW(32), .RR_MODE(0), .MAX_WAIT(3)) dut_f (
        .g_clk(g_clk), .g_reset(g_reset), .req_cen(req_cen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_stall(stall_f),
        .rsp_rvalid(rvalid_f), .rsp_rdata(rdata_f), .bram_cen(cen_f), .bram_addr(addr_f),
        .bram_wdata(wdata_f), .bram_wstrb(wstrb_f), .bram_rdata(mem_rd_f));

    frv_bram_arbiter #(.NPORTS(4), .AW(32), .DW(32), .RR_MODE(1), .MAX_WAIT(15)) dut_r (
        .g_clk(g_clk), .g_reset(g_reset), .req_cen(req_cen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_stall(stall_r),
        .rsp_rvalid(rvalid_r), .rsp_rdata(rdata_r), .bram_cen(cen_r), .bram_addr(addr_r),
        .bram_wdata(wdata_r), .bram_wstrb(wstrb_r), .bram_rdata(mem_rd_r));

    // One-cycle-latency byte-writable BRAM behind each arbiter.
    always @(posedge g_clk) begin
        if (cen_f) begin
            for (int b = 0; b < 4; b++) if (wstrb_f[b]) mem_f[addr_f[9:2]][b*8 +: 8] <= wdata_f[b*8 +: 8];
            mem_rd_f <= mem_f[addr_f[9:2]];
        end
        if (cen_r) begin
            for (int b = 0; b < 4; b++) if (wstrb_r[b]) mem_r[addr_r[9:2]][b*8 +: 8] <= wdata_r[b*8 +: 8];
            mem_rd_r <= mem_r[addr_r[9:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req_cen = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    endtask

    task automatic set_port(input int p, input logic cen, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        req_cen[p] = cen; req_addr[p*32 +: 32] = a; req_wdata[p*32 +: 32] = d; req_wstrb[p*4 +: 4] = s;
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e, g_f, g_r, nx_f, nx_r, exp_rv_f, exp_rv_r;
        int wf [4];
        int wr [4];
        int max_wf, max_wr;
        g_reset = 1'b1;
        idle();
        tick(); tick();
        #2 check("rst_stall", 32'(stall_f), 0);
        check("rst_rvalid", 32'(rvalid_f), 0);
        check("rst_cen_idle", 32'(cen_f), 0);
        set_port(1, 1'b1, 32'h40, 0, 4'h0);
        #2 check("rst_cen_comb", 32'(cen_f), 1);
        tick();
        g_reset = 1'b0;
        idle();
        set_port(0, 1'b1, 32'h100, 32'h11110100, 4'hF);
        tick(); idle();
        set_port(2, 1'b1, 32'h200, 32'h22220200, 4'hF);
        tick(); idle();
        #2 check("wr_no_rvalid", 32'(rvalid_f), 0);
        tick();

        set_port(0, 1'b1, 32'h100, 0, 4'h0);
        set_port(2, 1'b1, 32'h200, 0, 4'h0);
        #2 check("t1_stall_a", 32'(stall_f), 32'b0100);
        check("t1_addr_a", addr_f, 32'h100);
        tick();
        req_cen[0] = 1'b0;
        #2 check("t1_stall_b", 32'(stall_f), 0);
        check("t1_addr_b", addr_f, 32'h200);
        check("t1_rvalid_a", 32'(rvalid_f), 32'b0001);
        check("t1_rdata_a", rdata_f, 32'h11110100);
        tick(); idle();
        #2 check("t1_rvalid_b", 32'(rvalid_f), 32'b0100);
        check("t1_rdata_b", rdata_f, 32'h22220200);

        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        for (int p = 0; p < 4; p++) set_port(p, 1'b1, 32'h100, 0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            e = ~(4'b0001 << (c % 4));
            #2 check($sformatf("t2_stall_%0d", c), 32'(stall_r), 32'(e));
            if (c > 0) begin
                e = 4'b0001 << (c - 1);
                check($sformatf("t2_rvalid_%0d", c), 32'(rvalid_r), 32'(e));
                check($sformatf("t2_rdata_%0d", c), rdata_r, 32'h11110100);
            end
            tick();
        end

        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        idle();
        set_port(0, 1'b1, 32'h100, 0, 4'h0);
        set_port(3, 1'b1, 32'h200, 0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            e = c == 3 ? 4'b0001 : 4'b1000;
            #2 check($sformatf("t3_stall_%0d", c), 32'(stall_f), 32'(e));
            if (c == 4) check("t3_rvalid", 32'(rvalid_f), 32'b1000);
            tick();
        end
        idle();

        set_port(1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        #2 check("t4_wstrb", 32'(wstrb_f), 32'hF);
        check("t4_wdata", wdata_f, 32'hDEADBEEF);
        tick();
        set_port(1, 1'b1, 32'h40, 0, 4'h0);
        #2 check("t4_wr_no_rvalid", 32'(rvalid_f), 0);
        tick(); idle();
        #2 check("t4_rvalid", 32'(rvalid_f), 32'b0010);
        check("t4_rdata", rdata_f, 32'hDEADBEEF);

        set_port(2, 1'b1, 32'h200, 0, 4'h0);
        tick(); idle();
        g_reset = 1'b1;
        #2 check("t5_rvalid_f", 32'(rvalid_f), 0);
        check("t5_rvalid_r", 32'(rvalid_r), 0);
        tick();
        g_reset = 1'b0;
        for (int p = 0; p < 4; p++) set_port(p, 1'b1, 32'h100, 0, 4'h0);
        #2 check("t5_rr_ptr", 32'(stall_r), 32'b1110);
        check("t5_stall_f", 32'(stall_f), 32'b1110);
        check("t5_rvalid", 32'(rvalid_f), 0);
        tick(); idle(); tick();

        exp_rv_f = '0; exp_rv_r = '0; max_wf = 0; max_wr = 0;
        for (int p = 0; p < 4; p++) begin wf[p] = 0; wr[p] = 0; end
        for (int n = 0; n < 10000; n++) begin
            for (int p = 0; p < 4; p++)
                set_port(p, $urandom_range(0, 3) != 0, 32'($urandom_range(0, 255)) << 2, $urandom,
                         $urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom_range(0, 15)));
            #2;
            g_f = req_cen & ~stall_f;
            g_r = req_cen & ~stall_r;
            check("rnd_grant_f", 32'($countones(g_f)), (|req_cen) ? 1 : 0);
            check("rnd_grant_r", 32'($countones(g_r)), (|req_cen) ? 1 : 0);
            check("rnd_rvalid_f", 32'(rvalid_f), 32'(exp_rv_f));
            check("rnd_rvalid_r", 32'(rvalid_r), 32'(exp_rv_r));
            nx_f = '0; nx_r = '0;
            for (int p = 0; p < 4; p++) begin
                nx_f[p] = g_f[p] && req_wstrb[p*4 +: 4] == 4'h0;
                nx_r[p] = g_r[p] && req_wstrb[p*4 +: 4] == 4'h0;
                wf[p] = stall_f[p] ? wf[p] + 1 : 0;
                wr[p] = stall_r[p] ? wr[p] + 1 : 0;
                if (wf[p] > max_wf) max_wf = wf[p];
                if (wr[p] > max_wr) max_wr = wr[p];
            end
            tick();
            exp_rv_f = nx_f;
            exp_rv_r = nx_r;
        end
        check("rnd_wait_bound_f", 32'(max_wf <= 3 + 4), 1);
        check("rnd_wait_bound_r", 32'(max_wr <= 15 + 4), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
